// File: rtl/mux2x1_arb_pkg.sv
// Shared types and helpers for the two-source round-robin packet arbiter.
package mux2x1_arb_pkg;

  // Arbiter FSM states: idle, or locked onto source A or source B.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  // Mux select encodings (s=0 picks the A side, s=1 picks the B side).
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Round-robin pick: on a tie the source that was not served last wins.
  function automatic state_t arb_pick(input logic a_v, input logic b_v,
                                      input logic last_served);
    state_t pick;
    pick = IDLE;
    if (a_v && b_v) begin
      pick = (last_served == SEL_A) ? GNT_B : GNT_A;
    end else if (a_v) begin
      pick = GNT_A;
    end else if (b_v) begin
      pick = GNT_B;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux2x1_rr_arbiter_mux2x1.sv
// Single-bit 2:1 multiplexer cell: s=0 passes a, s=1 passes b.
module mux2x1 (
  input  logic s,
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one mux2x1 datapath between two
// valid/ready sources and driving a registered single output stream.
module mux2x1_rr_arbiter
  import mux2x1_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  output logic             err_long
);

  // Beat counter only has to reach MAX_BEATS-1; keep at least one bit.
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last_served;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_src;
  logic             r_err_long;

  logic             w_sel;
  logic             w_granted;
  logic             w_room;
  logic             w_x_valid;
  logic             w_x_last;
  logic [WIDTH-1:0] w_x_data;
  logic             w_accept;
  logic             w_force;
  logic             w_pkt_end;
  state_t           w_arb_idle;
  state_t           w_arb_end;

  assign w_sel     = (r_state == GNT_B);
  assign w_granted = (r_state == GNT_A) || (r_state == GNT_B);

  // Output register can take a new beat when empty or being drained this cycle.
  assign w_room  = !r_out_valid || out_ready;
  assign a_ready = (r_state == GNT_A) && w_room;
  assign b_ready = (r_state == GNT_B) && w_room;

  // Shared datapath: one mux cell per data bit plus one for last.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_data_mux
      mux2x1 u_mux_data (
        .s (w_sel),
        .a (a_data[gi]),
        .b (b_data[gi]),
        .y (w_x_data[gi])
      );
    end
  endgenerate

  mux2x1 u_mux_last (
    .s (w_sel),
    .a (a_last),
    .b (b_last),
    .y (w_x_last)
  );

  assign w_x_valid = w_sel ? b_valid : a_valid;
  assign w_accept  = w_granted && w_x_valid && w_room;

  // A packet that reaches MAX_BEATS without last is cut off on this beat.
  assign w_force   = (r_beat_cnt == CNT_LAST) && !w_x_last;
  assign w_pkt_end = w_accept && (w_x_last || w_force);

  // From IDLE the last-served source loses ties; at packet end the source just
  // served loses ties so the other side gets the next packet without a bubble.
  assign w_arb_idle = arb_pick(a_valid, b_valid, r_last_served);
  assign w_arb_end  = arb_pick(a_valid, b_valid, w_sel);

  // Next-state logic: hold the grant until the current packet ends.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:         w_state_next = w_arb_idle;
      GNT_A, GNT_B: if (w_pkt_end) w_state_next = w_arb_end;
      default:      w_state_next = IDLE;
    endcase
  end

  // State register, round-robin pointer and per-packet beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last_served <= SEL_B;
      r_beat_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pkt_end) begin
        r_last_served <= w_sel;
        r_beat_cnt    <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  // Registered output stage; a held beat stays put until the sink takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_x_data;
      r_out_last  <= w_x_last || w_force;
      r_out_src   <= w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overlong-packet flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_long <= 1'b0;
    end else if (w_accept && w_force) begin
      r_err_long <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;
  assign err_long  = r_err_long;

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Scoreboard bench for the round-robin packet arbiter (MAX_BEATS=16 and =4 instances).
module tb_mux2x1_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       use4;
  logic       a_valid, b_valid, a_last, b_last, out_ready;
  logic [7:0] a_data, b_data;

  logic       a_valid16, b_valid16, a_valid4, b_valid4;
  logic       a_ready16, b_ready16, out_valid16, out_last16, out_src16, err16;
  logic       a_ready4, b_ready4, out_valid4, out_last4, out_src4, err4;
  logic [7:0] out_data16, out_data4;

  logic       a_ready_v, b_ready_v, out_valid_v, out_last_v, out_src_v, err_v;
  logic [7:0] out_data_v;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ocount   = 0;
  int prev_ocyc = -1;
  logic chk_gap = 0, chk_b0 = 0, chk_stall = 0;
  logic pf_valid = 0;
  logic [7:0] pf_data = '0;

  logic [8:0] a_q[$];
  logic [8:0] b_q[$];
  logic [9:0] exp_q[$];

  assign a_valid16 = a_valid & ~use4;
  assign b_valid16 = b_valid & ~use4;
  assign a_valid4  = a_valid & use4;
  assign b_valid4  = b_valid & use4;

  assign a_ready_v   = use4 ? a_ready4   : a_ready16;
  assign b_ready_v   = use4 ? b_ready4   : b_ready16;
  assign out_valid_v = use4 ? out_valid4 : out_valid16;
  assign out_data_v  = use4 ? out_data4  : out_data16;
  assign out_last_v  = use4 ? out_last4  : out_last16;
  assign out_src_v   = use4 ? out_src4   : out_src16;
  assign err_v       = use4 ? err4       : err16;

  mux2x1_rr_arbiter #(.WIDTH(8), .MAX_BEATS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid16), .a_ready(a_ready16), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid16), .b_ready(b_ready16), .b_data(b_data), .b_last(b_last),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_last(out_last16), .out_src(out_src16), .err_long(err16)
  );

  mux2x1_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid4), .a_ready(a_ready4), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid4), .b_ready(b_ready4), .b_data(b_data), .b_last(b_last),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_last(out_last4), .out_src(out_src4), .err_long(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  // Present the head of each source queue.
  task automatic drive();
    a_valid = (a_q.size() != 0);
    a_data  = a_valid ? a_q[0][7:0] : 8'h00;
    a_last  = a_valid ? a_q[0][8]   : 1'b0;
    b_valid = (b_q.size() != 0);
    b_data  = b_valid ? b_q[0][7:0] : 8'h00;
    b_last  = b_valid ? b_q[0][8]   : 1'b0;
  endtask

  // One clock: drive, sample at negedge, advance queues after the edge.
  task automatic step();
    logic af, bf;
    logic [9:0] e;
    drive();
    @(negedge clk);
    cyc++;
    if (pf_valid) begin
      check_eq("lat_valid", out_valid_v, 1);
      check_eq("lat_data", out_data_v, pf_data);
    end
    if (chk_b0) check_eq("b_ready_low", b_ready_v, 0);
    if (chk_stall) begin
      check_eq("stall_valid", out_valid_v, 1);
      check_eq("stall_a_ready", a_ready_v, 0);
      if (exp_q.size() != 0) check_eq("stall_data", out_data_v, exp_q[0][7:0]);
    end
    af = rst_n & a_valid & a_ready_v;
    bf = rst_n & b_valid & b_ready_v;
    if (rst_n && out_valid_v && out_ready) begin
      $display("beat cyc=%0d src=%0d data=0x%02h last=%0d err=%0d",
               cyc, out_src_v, out_data_v, out_last_v, err_v);
      if (exp_q.size() == 0) begin
        check_eq("spurious_beat", out_valid_v, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_beat", {22'd0, out_src_v, out_last_v, out_data_v}, {22'd0, e});
        if (chk_gap && prev_ocyc >= 0) check_eq("beat_gap", cyc - prev_ocyc, 1);
        prev_ocyc = cyc;
        ocount++;
      end
    end
    pf_valid = af | bf;
    pf_data  = af ? a_data : b_data;
    @(posedge clk);
    #1;
    if (af) void'(a_q.pop_front());
    if (bf) void'(b_q.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    pf_valid  = 1'b0;
    prev_ocyc = -1;
    ocount    = 0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int k);
    int n = 0;
    while (ocount < k && n < 300) begin
      step();
      n++;
    end
    check_eq("wait_beats", ocount, k);
  endtask

  initial begin
    rst_n = 1'b0; use4 = 1'b0; out_ready = 1'b1;
    a_valid = 0; b_valid = 0; a_last = 0; b_last = 0; a_data = 0; b_data = 0;
    do_reset();
    do_reset();
    check_eq("rst_out_valid", out_valid_v, 0);
    check_eq("rst_out_data", out_data_v, 0);
    check_eq("rst_out_last", out_last_v, 0);
    check_eq("rst_out_src", out_src_v, 0);
    check_eq("rst_err_long", err_v, 0);
    check_eq("rst_ready", {a_ready_v, b_ready_v}, 0);

    // Test 1: single 3-beat A packet.
    a_q = '{9'h011, 9'h022, 9'h133};
    exp_q = '{10'h011, 10'h022, 10'h133};
    chk_b0 = 1;
    drain();
    chk_b0 = 0;

    // Test 2: both sources from reset, alternating 2-beat packets, no bubble.
    do_reset();
    a_q = '{9'h041, 9'h142, 9'h043, 9'h144};
    b_q = '{9'h051, 9'h152};
    exp_q = '{10'h041, 10'h142, 10'h251, 10'h352, 10'h043, 10'h144};
    chk_gap = 1;
    drain();
    chk_gap = 0;

    // Test 3: sink stalls 4 cycles mid-packet.
    do_reset();
    a_q = '{9'h061, 9'h062, 9'h063, 9'h164};
    exp_q = '{10'h061, 10'h062, 10'h063, 10'h164};
    wait_beats(2);
    out_ready = 1'b0;
    chk_stall = 1;
    repeat (4) step();
    chk_stall = 0;
    out_ready = 1'b1;
    prev_ocyc = -1;
    chk_gap = 1;
    drain();
    chk_gap = 0;
    check_eq("t3_src_empty", a_q.size(), 0);

    // Test 4: MAX_BEATS=4, overlong A packet forced closed, B gets the grant.
    use4 = 1'b1;
    do_reset();
    a_q = '{9'h071, 9'h072, 9'h073, 9'h074, 9'h075, 9'h076, 9'h177};
    b_q = '{9'h081, 9'h182};
    exp_q = '{10'h071, 10'h072, 10'h073, 10'h174, 10'h281, 10'h382,
              10'h075, 10'h076, 10'h177};
    wait_beats(2);
    check_eq("t4_err_before", err_v, 0);
    drain();
    check_eq("t4_err_set", err_v, 1);
    repeat (3) step();
    check_eq("t4_err_sticky", err_v, 1);

    // Test 5: reset after the 2nd beat of an A packet, then a tie goes to A.
    a_q = '{9'h091, 9'h092, 9'h093, 9'h194};
    exp_q = '{10'h091, 10'h092, 10'h093, 10'h194};
    ocount = 0;
    wait_beats(2);
    do_reset();
    check_eq("t5_out_valid", out_valid_v, 0);
    check_eq("t5_err_long", err_v, 0);
    check_eq("t5_ready", {a_ready_v, b_ready_v}, 0);
    a_q = '{9'h1A1};
    b_q = '{9'h1B1};
    exp_q = '{10'h1A1, 10'h3B1};
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
